// File: rtl/note_window_loader.sv
// rtl/note_window_loader.sv - per-frame note window scanner with tear-free double buffer
module note_window_loader #(
  parameter int DISPLAYED_BEATS    = 4,
  parameter int SIMULTANEOUS_NOTES = 4,
  parameter int BEAT_BITS          = 8,
  parameter int NOTE_BITS          = 6,
  parameter int ADDR_BITS          = 10,
  parameter int NOTE_STATE_BITS    = NOTE_BITS + 2*BEAT_BITS,
  parameter int NOTES_STATE_SIZE   = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [BEAT_BITS-1:0]       cur_beat,
  input  logic                       reset_player,
  output logic [ADDR_BITS-1:0]       mem_addr,
  input  logic [NOTE_STATE_BITS-1:0] mem_data,
  output logic [NOTE_STATE_BITS-1:0] notes [NOTES_STATE_SIZE],
  output logic                       valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int IDX_W = $clog2(NOTES_STATE_SIZE);
  localparam int CNT_W = $clog2(NOTES_STATE_SIZE + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                     state_q;
  logic [NOTE_STATE_BITS-1:0] active_q [NOTES_STATE_SIZE];
  logic [NOTE_STATE_BITS-1:0] shadow_q [NOTES_STATE_SIZE];
  logic [ADDR_BITS-1:0]       mem_addr_q;
  logic [BEAT_BITS-1:0]       wbeg_q;
  logic [BEAT_BITS:0]         wend_q;
  logic [CNT_W-1:0]           count_q;
  logic                       fetched_q;
  logic                       valid_q;
  logic                       busy_q;
  logic                       overrun_q;

  logic [BEAT_BITS-1:0] ent_start;
  logic [BEAT_BITS-1:0] ent_dur;
  logic [BEAT_BITS:0]   ent_end;
  logic                 is_term;
  logic                 past_window;
  logic                 hit;
  logic                 full_after;
  logic                 last_addr;
  logic                 stop;

  // Decode the entry returned for the previous address and decide include/stop.
  // The address being evaluated is mem_addr_q-1, so mem_addr_q==0 means the
  // top address is under evaluation.
  always_comb begin
    ent_start   = mem_data[2*BEAT_BITS-1 -: BEAT_BITS];
    ent_dur     = mem_data[BEAT_BITS-1:0];
    ent_end     = {1'b0, ent_start} + {1'b0, ent_dur};
    is_term     = (ent_dur == '0);
    past_window = ({1'b0, ent_start} >= wend_q);
    hit         = !is_term && !past_window && (ent_end > {1'b0, wbeg_q});
    full_after  = hit && (count_q == CNT_W'(NOTES_STATE_SIZE - 1));
    last_addr   = (mem_addr_q == '0);
    stop        = is_term || past_window || full_after || last_addr;
  end

  // Scan FSM: every state restarts a scan on frame_start; DONE also publishes
  // the shadow buffer, SCAN flags an overrun. reset_player overrides all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mem_addr_q <= '0;
      wbeg_q     <= '0;
      wend_q     <= '0;
      count_q    <= '0;
      fetched_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NOTES_STATE_SIZE; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      overrun_q <= 1'b0;
      if (reset_player) begin
        state_q    <= IDLE;
        mem_addr_q <= '0;
        count_q    <= '0;
        fetched_q  <= 1'b0;
        valid_q    <= 1'b0;
        busy_q     <= 1'b0;
        for (int i = 0; i < NOTES_STATE_SIZE; i++) begin
          active_q[i] <= '0;
          shadow_q[i] <= '0;
        end
      end else if (frame_start) begin
        if (state_q == SCAN) begin
          overrun_q <= 1'b1;
        end
        if (state_q == DONE) begin
          for (int i = 0; i < NOTES_STATE_SIZE; i++) begin
            active_q[i] <= shadow_q[i];
          end
          valid_q <= 1'b1;
        end
        for (int i = 0; i < NOTES_STATE_SIZE; i++) begin
          shadow_q[i] <= '0;
        end
        wbeg_q     <= cur_beat;
        wend_q     <= {1'b0, cur_beat} + (BEAT_BITS+1)'(DISPLAYED_BEATS);
        count_q    <= '0;
        mem_addr_q <= '0;
        fetched_q  <= 1'b0;
        busy_q     <= 1'b1;
        state_q    <= SCAN;
      end else if (state_q == SCAN) begin
        mem_addr_q <= mem_addr_q + ADDR_BITS'(1);
        fetched_q  <= 1'b1;
        if (fetched_q) begin
          if (hit) begin
            shadow_q[count_q[IDX_W-1:0]] <= mem_data;
            count_q                      <= count_q + CNT_W'(1);
          end
          if (stop) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign notes    = active_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_note_window_loader.sv
// tb/tb_note_window_loader.sv - directed self-checking bench for note_window_loader
module tb_note_window_loader;

  localparam int NSB   = 22;
  localparam int NSS   = 32;
  localparam int DEPTH = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           frame_start = 1'b0;
  logic [7:0]     cur_beat = '0;
  logic           reset_player = 1'b0;
  logic [9:0]     mem_addr;
  logic [NSB-1:0] mem_data = '0;
  logic [NSB-1:0] notes [NSS];
  logic           valid;
  logic           busy;
  logic           overrun;

  logic [NSB-1:0] mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  note_window_loader dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .cur_beat     (cur_beat),
    .reset_player (reset_player),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .notes        (notes),
    .valid        (valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Registered song ROM, one-cycle read latency.
  always_ff @(posedge clk) mem_data <= mem[mem_addr];

  typedef struct {
    logic [7:0]     beat;
    logic [NSB-1:0] entry;
    logic           incl;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [NSB-1:0] ent(input int n, input int s, input int d);
    ent = {n[5:0], s[7:0], d[7:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nonzero_slots(input int from);
    int n = 0;
    for (int i = from; i < NSS; i++) if (notes[i] != '0) n++;
    return n;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  endtask

  // Called at a negedge; frame_start is seen by exactly one posedge.
  task automatic pulse_frame(input logic [7:0] beat);
    frame_start = 1'b1;
    cur_beat    = beat;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_reset_player();
    reset_player = 1'b1;
    @(negedge clk);
    reset_player = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cyc);
    cyc = 0;
    while (busy && cyc < bound) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic load_basic();
    clear_mem();
    mem[0] = ent(5, 0, 2);
    mem[1] = ent(7, 1, 1);
    mem[2] = ent(9, 6, 1);
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0] = '{8'd5,   ent(3, 0, 8),    1'b1};
    vecs[1] = '{8'd5,   ent(4, 2, 3),    1'b0};
    vecs[2] = '{8'd5,   ent(6, 8, 1),    1'b1};
    vecs[3] = '{8'd5,   ent(6, 9, 1),    1'b0};
    vecs[4] = '{8'd5,   ent(2, 4, 2),    1'b1};
    vecs[5] = '{8'd255, ent(1, 250, 10), 1'b1};
    vecs[6] = '{8'd0,   ent(0, 0, 0),    1'b0};
    vecs[7] = '{8'd10,  ent(9, 3, 2),    1'b0};

    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_valid",    valid,    0);
    check("reset_busy",     busy,     0);
    check("reset_overrun",  overrun,  0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_notes",    nonzero_slots(0), 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic three-entry song.
    load_basic();
    pulse_frame(8'd0);
    check("basic_busy_start", busy, 1);
    wait_idle(2000, cyc);
    check("basic_busy_cycles", cyc, 4);
    check("basic_valid_before", valid, 0);
    pulse_frame(8'd0);
    check("basic_valid", valid, 1);
    check("basic_slot0", notes[0], ent(5, 0, 2));
    check("basic_slot1", notes[1], ent(7, 1, 1));
    check("basic_rest",  nonzero_slots(2), 0);
    wait_idle(2000, cyc);

    // Window overlap table.
    for (int v = 0; v < 8; v++) begin
      pulse_reset_player();
      clear_mem();
      mem[0] = vecs[v].entry;
      pulse_frame(vecs[v].beat);
      wait_idle(2000, cyc);
      pulse_frame(8'd0);
      check($sformatf("vec%0d_slot0", v), notes[0], vecs[v].incl ? vecs[v].entry : '0);
      check($sformatf("vec%0d_valid", v), valid, 1);
      wait_idle(2000, cyc);
    end

    // Full buffer: 40 candidates, only the first 32 land.
    pulse_reset_player();
    clear_mem();
    for (int i = 0; i < 40; i++) mem[i] = ent(i + 1, 0, 4);
    pulse_frame(8'd0);
    wait_idle(2000, cyc);
    check("full_busy_cycles", cyc, 33);
    pulse_frame(8'd0);
    bad = 0;
    for (int i = 0; i < NSS; i++) if (notes[i] !== ent(i + 1, 0, 4)) bad++;
    check("full_slots_wrong", bad, 0);
    wait_idle(2000, cyc);

    // No terminator, nothing in window: scan ends at the top address.
    pulse_reset_player();
    for (int i = 0; i < DEPTH; i++) mem[i] = ent(1, 0, 1);
    pulse_frame(8'd5);
    wait_idle(2000, cyc);
    check("maxaddr_busy_cycles", cyc, 1025);
    pulse_frame(8'd5);
    check("maxaddr_valid", valid, 1);
    check("maxaddr_empty", nonzero_slots(0), 0);
    wait_idle(2000, cyc);

    // Overrun: frame_start two cycles into a scan.
    pulse_reset_player();
    load_basic();
    pulse_frame(8'd0);
    wait_idle(2000, cyc);
    pulse_frame(8'd0);
    @(negedge clk);
    pulse_frame(8'd3);
    check("ovr_pulse",    overrun,  1);
    check("ovr_mem_addr", mem_addr, 0);
    check("ovr_busy",     busy,     1);
    check("ovr_valid",    valid,    1);
    check("ovr_slot0",    notes[0], ent(5, 0, 2));
    check("ovr_slot1",    notes[1], ent(7, 1, 1));
    @(negedge clk);
    check("ovr_one_cycle", overrun, 0);
    wait_idle(2000, cyc);
    check("ovr_rescan_cycles", cyc, 4);
    pulse_frame(8'd0);
    check("ovr_new_slot0", notes[0], ent(9, 6, 1));
    check("ovr_new_rest",  nonzero_slots(1), 0);

    // reset_player mid-scan, coincident with frame_start.
    @(negedge clk);
    reset_player = 1'b1;
    frame_start  = 1'b1;
    @(negedge clk);
    reset_player = 1'b0;
    frame_start  = 1'b0;
    check("rp_valid",   valid,   0);
    check("rp_busy",    busy,    0);
    check("rp_overrun", overrun, 0);
    check("rp_notes",   nonzero_slots(0), 0);
    pulse_frame(8'd0);
    check("rp_fresh_busy", busy, 1);
    wait_idle(2000, cyc);
    check("rp_fresh_cycles", cyc, 4);
    pulse_frame(8'd0);
    check("rp_fresh_slot0", notes[0], ent(5, 0, 2));
    check("rp_fresh_valid", valid, 1);
    wait_idle(2000, cyc);

    // Asynchronous reset in DONE, between clock edges.
    #2 rst = 1'b0;
    #1;
    check("async_valid",    valid,    0);
    check("async_mem_addr", mem_addr, 0);
    check("async_notes",    nonzero_slots(0), 0);
    check("async_busy",     busy,     0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_window_loader.md
Name: note_window_loader

Overview:
- Scheduler/loader feeding the `display` block's `notes` array and `valid` input.
- Once per video frame, scans the song note memory and collects every note overlapping the visible beat window into a shadow buffer.
- Presents the shadow buffer to the display only at a frame boundary, so the screen never tears mid-frame.
- Sits between the song ROM and `display`, driven by the pixel timing generator's frame pulse and the player's current beat.

Parameters:
- DISPLAYED_BEATS, 4: beats visible on screen.
- SIMULTANEOUS_NOTES, 4: notes displayable at once.
- BEAT_BITS, 8: width of a beat index or duration.
- NOTE_BITS, 6: width of a note code.
- ADDR_BITS, 10: song memory address width.
- Derived: NOTE_STATE_BITS = NOTE_BITS + 2*BEAT_BITS.
- Derived: NOTES_STATE_SIZE = 2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- cur_beat  in  BEAT_BITS  current song beat, sampled at frame_start
- reset_player  in  1  song change/restart; aborts scan and clears valid
- mem_addr  out  ADDR_BITS  song memory read address
- mem_data  in  NOTE_STATE_BITS  entry {note, start_beat, duration}, MSB→LSB; registered, 1-cycle read latency
- notes  out  NOTE_STATE_BITS x NOTES_STATE_SIZE (unpacked array)  active slots to display
- valid  out  1  active buffer holds a completed window
- busy  out  1  scan in progress
- overrun  out  1  one-cycle pulse: frame_start arrived before scan finished

Behaviour:
- Reset (rst=0, async): state IDLE; all active and shadow slots 0; mem_addr=0; valid=0; busy=0; overrun=0.
- Empty slot encoding: all zeros (duration 0). Display treats it as no note.
- Song memory format:
  - Entries sorted by start_beat ascending.
  - First entry with duration 0 is the terminator.
- States: IDLE, SCAN, DONE.
- IDLE: on frame_start:
  - latch wbeg = cur_beat and wend = cur_beat + DISPLAYED_BEATS (BEAT_BITS+1 bits, no wrap);
  - clear all shadow slots; slot count = 0; mem_addr = 0;
  - go to SCAN; busy=1.
- SCAN: mem_addr increments by 1 each cycle. The entry returned one cycle after its address is evaluated:
  - end = start + duration, computed in BEAT_BITS+1 bits.
  - Include when duration != 0 AND end > wbeg AND start < wend. Written to shadow[count]; count++.
  - Stop on the first of:
    - terminator (duration 0);
    - start >= wend;
    - count reaches NOTES_STATE_SIZE after a write;
    - evaluation of address 2^ADDR_BITS-1.
  - On stop: go to DONE; busy=0. The entry fetched speculatively in the stop cycle is discarded.
- DONE: on frame_start:
  - copy shadow → active notes; valid=1;
  - in the same cycle, start a new scan exactly as from IDLE using the new cur_beat.
- notes/valid change only on a DONE-state frame_start, i.e. one frame of latency from sampled beat to display.
- frame_start during SCAN:
  - overrun=1 for one cycle;
  - active buffer and valid unchanged;
  - scan restarts from address 0 with the new cur_beat.
- reset_player=1 (any state, highest priority, same cycle as frame_start included):
  - valid=0; active and shadow cleared; state IDLE; busy=0; no overrun pulse.
- Scan length: at most 2^ADDR_BITS+1 cycles. The design requires this to be shorter than a frame.

Test Plan:
- Reset then memory {n5,s0,d2},{n7,s1,d1},{n9,s6,d1},term; frame_start with cur_beat=0:
  - busy for 4 cycles, then DONE;
  - next frame_start → notes[0]={5,0,2}, notes[1]={7,1,1}, other slots 0, valid=1.
- Window overlap: {n3,s0,d8} with cur_beat=5 → included (end 8 > 5); {n4,s2,d3} → excluded (end 5 not > 5).
- Full: 40 entries all at start 0, d4, slots=32 → exactly 32 written, scan stops after the 32nd, remaining entries ignored.
- Overrun: frame_start 2 cycles after scan start → overrun pulses once, valid/notes unchanged, mem_addr back to 0.
- reset_player asserted mid-SCAN with valid=1 → valid=0, all notes 0, busy=0 next cycle; next frame_start begins a fresh scan.
- Async reset while in DONE: rst low between clock edges → outputs zero immediately without a clk edge.
